// File: rtl/pq_board_ctl.sv
// pq_board_ctl: debounced pushbutton front end that sequences enqueue/dequeue commands into a priority queue and drives eight digit codes.
// Latency: button press to enq/deq pulse is DB_CYCLES+3 cycles; pulse to pq_enq/pq_deq strobe is 2 cycles plus one per pq_busy cycle in WAIT.
// Backpressure: waits on pq_busy before and after each strobe; full/empty commands are rejected (err); presses outside IDLE are dropped.
// Optional feature macro PQ_BOARD_OCC_DISPLAY_EN: when defined, d7/d6 show occ in hex; otherwise they are blank.
module pq_board_ctl #(
   parameter int KEY_W     = 8,
   parameter int VAL_W     = 8,
   parameter int DEPTH     = 16,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [KEY_W+VAL_W-1:0]       kv_sw,
   input  logic                         enq_btn,
   input  logic                         deq_btn,
   input  logic                         pq_busy,
   input  logic                         pq_full,
   input  logic                         pq_empty,
   input  logic [KEY_W+VAL_W-1:0]       pq_kvo,
   output logic                         pq_enq,
   output logic                         pq_deq,
   output logic [KEY_W+VAL_W-1:0]       pq_kvi,
   output logic [$clog2(DEPTH+1)-1:0]   occ,
   output logic                         err,
   output logic                         ctl_busy,
   output logic [6:0]                   d7,
   output logic [6:0]                   d6,
   output logic [6:0]                   d5,
   output logic [6:0]                   d4,
   output logic [6:0]                   d3,
   output logic [6:0]                   d2,
   output logic [6:0]                   d1,
   output logic [6:0]                   d0
);
   localparam int KV_W  = KEY_W + VAL_W;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int NDIG  = KV_W / 4;
   localparam int DBC_W = $clog2(DB_CYCLES + 1);
   localparam logic [6:0] BLANK = 7'h7F;

   // Parameter sanity: the display only has four data digits, and occ must fit two hex digits.
   generate
      if ((KV_W % 4) != 0 || KV_W > 16 || KV_W < 4) begin : g_bad_kv_w
         $error("pq_board_ctl: KEY_W+VAL_W must be a multiple of 4 and at most 16");
      end
      if (DEPTH < 1 || DEPTH > 255) begin : g_bad_depth
         $error("pq_board_ctl: DEPTH must be in 1..255");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_SETTLE} state_t;

   logic [1:0]       w_btn_raw;
   logic [1:0]       r_sync1, r_sync2, r_db, r_db_d, r_pulse;
   logic [DBC_W-1:0] r_cnt [2];
   state_t           r_state, w_state_nxt;
   logic             w_enq_p, w_deq_p, w_deq_ok, w_enq_ok;
   logic             w_acc_enq, w_acc_deq, w_reject, w_enq_nxt, w_deq_nxt;
   logic             r_cmd_deq, r_pq_enq, r_pq_deq, r_err, r_ctl_busy;
   logic [KV_W-1:0]  r_pq_kvi, r_last_kv;
   logic [OCC_W-1:0] r_occ;
   logic [15:0]      w_kv16;
   logic [6:0]       w_dig [4];

   // Index 0 is the enqueue button, index 1 the dequeue button.
   assign w_btn_raw = {deq_btn, enq_btn};
   assign w_enq_p   = r_pulse[0];
   assign w_deq_p   = r_pulse[1];

   // Button path: 2-flop synchronizer, stability counter, registered rising-edge pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_db    <= '0;
         r_db_d  <= '0;
         r_pulse <= '0;
         r_cnt   <= '{default: '0};
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
         r_db_d  <= r_db;
         r_pulse <= r_db & ~r_db_d;
         for (int b = 0; b < 2; b++) begin
            if (r_sync2[b] == r_db[b]) begin
               r_cnt[b] <= '0;
            end else if (r_cnt[b] == DBC_W'(DB_CYCLES - 1)) begin
               r_db[b]  <= r_sync2[b];
               r_cnt[b] <= '0;
            end else begin
               r_cnt[b] <= r_cnt[b] + DBC_W'(1);
            end
         end
      end
   end

   // Command acceptance in IDLE; dequeue has priority and a simultaneous enqueue is dropped.
   assign w_deq_ok  = (r_occ != '0) && !pq_empty;
   assign w_enq_ok  = (r_occ != OCC_W'(DEPTH)) && !pq_full;
   assign w_acc_deq = (r_state == S_IDLE) && w_deq_p && w_deq_ok;
   assign w_acc_enq = (r_state == S_IDLE) && !w_deq_p && w_enq_p && w_enq_ok;
   assign w_reject  = (r_state == S_IDLE) && (w_deq_p ? !w_deq_ok : (w_enq_p && !w_enq_ok));

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_acc_deq || w_acc_enq) w_state_nxt = S_WAIT;
         S_WAIT:   if (!pq_busy) w_state_nxt = S_ISSUE;
         S_ISSUE:  w_state_nxt = S_SETTLE;
         S_SETTLE: if (!pq_busy) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: strobe values to register so they are high exactly during ISSUE.
   always_comb begin
      w_enq_nxt = 1'b0;
      w_deq_nxt = 1'b0;
      if (r_state == S_WAIT && !pq_busy) begin
         w_enq_nxt = !r_cmd_deq;
         w_deq_nxt = r_cmd_deq;
      end
   end

   // Command latch, strobes, occupancy, error flag and captured head value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cmd_deq  <= 1'b0;
         r_pq_kvi   <= '0;
         r_pq_enq   <= 1'b0;
         r_pq_deq   <= 1'b0;
         r_last_kv  <= '0;
         r_occ      <= '0;
         r_err      <= 1'b0;
         r_ctl_busy <= 1'b0;
      end else begin
         r_pq_enq   <= w_enq_nxt;
         r_pq_deq   <= w_deq_nxt;
         r_ctl_busy <= (w_state_nxt != S_IDLE);
         if (w_acc_deq || w_acc_enq) begin
            r_cmd_deq <= w_acc_deq;
            r_err     <= 1'b0;
         end else if (w_reject) begin
            r_err <= 1'b1;
         end
         if (w_acc_enq) r_pq_kvi <= kv_sw;
         // Strobes are high only in ISSUE, so this edge is the one that ends ISSUE.
         if (r_pq_enq) r_occ <= r_occ + OCC_W'(1);
         if (r_pq_deq) begin
            r_occ     <= r_occ - OCC_W'(1);
            r_last_kv <= pq_kvo;
         end
      end
   end

   assign pq_enq   = r_pq_enq;
   assign pq_deq   = r_pq_deq;
   assign pq_kvi   = r_pq_kvi;
   assign occ      = r_occ;
   assign err      = r_err;
   assign ctl_busy = r_ctl_busy;

   // Data digits: hex nibbles of last_kv, blank above the width in use.
   assign w_kv16 = 16'(r_last_kv);
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_dig[i] = (i < NDIG) ? {3'b000, w_kv16[4*i +: 4]} : BLANK;
      end
   end

   assign d0 = w_dig[0];
   assign d1 = w_dig[1];
   assign d2 = w_dig[2];
   assign d3 = w_dig[3];
   assign d4 = r_err ? 7'h0E : BLANK;
   assign d5 = BLANK;

`ifdef PQ_BOARD_OCC_DISPLAY_EN
   logic [7:0] w_occ8;
   assign w_occ8 = 8'(r_occ);
   assign d7 = {3'b000, w_occ8[7:4]};
   assign d6 = {3'b000, w_occ8[3:0]};
`else
   assign d7 = BLANK;
   assign d6 = BLANK;
`endif

endmodule

// File: tb/tb_pq_board_ctl.sv
// tb_pq_board_ctl: directed plus randomized command sequences against a queue-level reference model.
// Latency: each command step spans 40 cycles, enough for debounce, strobe, settle and button release.
// Backpressure: pq_busy is driven by the bench to stretch WAIT; a FIFO stand-in supplies full/empty/head.
`timescale 1ns/1ps
module tb_pq_board_ctl;
   localparam int DEPTH = 16;
   localparam int DB    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] kv_sw = '0;
   logic        enq_btn = 1'b0;
   logic        deq_btn = 1'b0;
   logic        pq_busy = 1'b0;
   logic        pq_full = 1'b0;
   logic        pq_empty = 1'b1;
   logic [15:0] pq_kvo = '0;
   logic        pq_enq, pq_deq, err, ctl_busy;
   logic [15:0] pq_kvi;
   logic [4:0]  occ;
   logic [6:0]  d7, d6, d5, d4, d3, d2, d1, d0;

   always #5 clk = ~clk;

   pq_board_ctl #(.KEY_W(8), .VAL_W(8), .DEPTH(DEPTH), .DB_CYCLES(DB)) dut (
      .clk(clk), .rst(rst), .kv_sw(kv_sw), .enq_btn(enq_btn), .deq_btn(deq_btn),
      .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty), .pq_kvo(pq_kvo),
      .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .occ(occ), .err(err),
      .ctl_busy(ctl_busy), .d7(d7), .d6(d6), .d5(d5), .d4(d4),
      .d3(d3), .d2(d2), .d1(d1), .d0(d0)
   );

   // Queue stand-in: a FIFO whose head is presented on pq_kvo.
   logic [15:0] pq_store [$];
   always @(posedge clk) begin
      if (pq_enq && pq_store.size() < DEPTH) pq_store.push_back(pq_kvi);
      if (pq_deq && pq_store.size() > 0) void'(pq_store.pop_front());
      pq_empty <= (pq_store.size() == 0);
      pq_full  <= (pq_store.size() == DEPTH);
      pq_kvo   <= (pq_store.size() > 0) ? pq_store[0] : 16'h0000;
   end

   // Cycle counter and strobe monitor, sampled on the falling edge.
   int          cyc = 0;
   int          n_enq = 0, n_deq = 0, str_cyc = 0;
   logic [15:0] kvi_seen = '0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (pq_enq || pq_deq) str_cyc = cyc;
      if (pq_enq) begin n_enq++; kvi_seen = pq_kvi; end
      if (pq_deq) n_deq++;
   end

   // Reference model: queue contents, sticky error, last dequeued value.
   logic [15:0] m_q [$];
   bit          m_err = 1'b0;
   logic [15:0] m_last = '0;

   int n_chk = 0, n_pass = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_disp(input string tag);
      check({tag, "_d0"}, d0, {3'b000, m_last[3:0]});
      check({tag, "_d1"}, d1, {3'b000, m_last[7:4]});
      check({tag, "_d2"}, d2, {3'b000, m_last[11:8]});
      check({tag, "_d3"}, d3, {3'b000, m_last[15:12]});
      check({tag, "_d4"}, d4, m_err ? 7'h0E : 7'h7F);
      check({tag, "_d5"}, d5, 7'h7F);
`ifdef PQ_BOARD_OCC_DISPLAY_EN
      check({tag, "_d7"}, d7, 32'(m_q.size()) / 16);
      check({tag, "_d6"}, d6, 32'(m_q.size()) % 16);
`else
      check({tag, "_d7"}, d7, 7'h7F);
      check({tag, "_d6"}, d6, 7'h7F);
`endif
   endtask

   // One command: press button(s) right after a rising edge, hold pq_busy for bw extra WAIT cycles.
   task automatic do_cmd(input bit e, input bit d, input logic [15:0] kv, input int bw, input string tag);
      int  c0, e0, dq0, rel, exp_at;
      bit  acc_e, acc_d, rej;
      acc_d  = d && (m_q.size() > 0);
      acc_e  = !d && e && (m_q.size() < DEPTH);
      rej    = (d && m_q.size() == 0) || (!d && e && m_q.size() == DEPTH);
      // Pulse appears DB+3 edges after press, WAIT begins one edge later.
      rel    = DB + 4 + bw;
      exp_at = (bw > 0) ? rel + 1 : DB + 5;
      e0 = n_enq; dq0 = n_deq;
      kv_sw = kv; pq_busy = (bw > 0); c0 = cyc;
      enq_btn = e; deq_btn = d;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == DB + 4) begin enq_btn = 1'b0; deq_btn = 1'b0; end
         if (bw > 0 && k == rel) pq_busy = 1'b0;
      end
      check({tag, "_nenq"}, n_enq - e0, 32'(acc_e));
      check({tag, "_ndeq"}, n_deq - dq0, 32'(acc_d));
      if (acc_e || acc_d) check({tag, "_lat"}, str_cyc - c0, exp_at);
      if (acc_e) check({tag, "_kvi"}, kvi_seen, kv);
      if (acc_d) begin m_last = m_q.pop_front(); m_err = 1'b0; end
      if (acc_e) begin m_q.push_back(kv); m_err = 1'b0; end
      if (rej) m_err = 1'b1;
      check({tag, "_occ"}, occ, m_q.size());
      check({tag, "_err"}, err, m_err);
      check({tag, "_busy"}, ctl_busy, 1'b0);
      check_disp(tag);
   endtask

   initial begin
      int e0, dq0, r;
      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_enq", pq_enq, 1'b0);
      check("rst_deq", pq_deq, 1'b0);
      check("rst_kvi", pq_kvi, 16'h0000);
      check("rst_occ", occ, 0);
      check("rst_err", err, 1'b0);
      check("rst_busy", ctl_busy, 1'b0);
      check_disp("rst");
      rst = 1'b0;

      // Reset while a command waits on busy: no strobe afterwards.
      e0 = n_enq;
      pq_busy = 1'b1; enq_btn = 1'b1; kv_sw = 16'hBEEF;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 10) begin rst = 1'b1; enq_btn = 1'b0; end
         if (k == 12) begin rst = 1'b0; pq_busy = 1'b0; end
      end
      check("midrst_nenq", n_enq - e0, 0);
      check("midrst_occ", occ, 0);
      check("midrst_busy", ctl_busy, 1'b0);

      // Directed commands.
      do_cmd(1'b1, 1'b0, 16'h3A5C, 0, "enq3a5c");
      do_cmd(1'b0, 1'b1, 16'h0000, 0, "deq1");
      do_cmd(1'b1, 1'b0, 16'h1234, 0, "enq1234");
      do_cmd(1'b0, 1'b1, 16'h0000, 5, "deqbusy");
      do_cmd(1'b0, 1'b1, 16'h0000, 0, "deqempty");
      do_cmd(1'b1, 1'b0, 16'h00FF, 0, "enqclr");
      do_cmd(1'b1, 1'b0, 16'h0101, 2, "enq2");
      do_cmd(1'b1, 1'b1, 16'h7777, 0, "both");

      // Two-cycle glitch must not survive the debouncer.
      e0 = n_enq;
      enq_btn = 1'b1;
      repeat (2) @(posedge clk);
      #1 enq_btn = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("glitch_nenq", n_enq - e0, 0);
      check("glitch_occ", occ, m_q.size());

      // Dequeue press whose pulse lands in SETTLE of an enqueue is dropped.
      e0 = n_enq; dq0 = n_deq;
      kv_sw = 16'hC0DE; enq_btn = 1'b1;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk); #1;
         if (k == 3) deq_btn = 1'b1;
         if (k == DB + 4) enq_btn = 1'b0;
         if (k == DB + 7) deq_btn = 1'b0;
      end
      m_q.push_back(16'hC0DE); m_err = 1'b0;
      check("settle_nenq", n_enq - e0, 1);
      check("settle_ndeq", n_deq - dq0, 0);
      check("settle_occ", occ, m_q.size());
      check("settle_err", err, m_err);

      // Randomized command mix.
      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 9);
         do_cmd((r < 4) || (r >= 8), (r >= 4), 16'($urandom), $urandom_range(0, 3), "rnd");
      end

      // Fill to capacity, then an enqueue is rejected.
      while (m_q.size() < DEPTH) do_cmd(1'b1, 1'b0, 16'($urandom), 0, "fill");
      do_cmd(1'b1, 1'b0, 16'hAAAA, 0, "enqfull");
      check("full_err", err, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
